// File: rtl/mc_pkg.sv
// Shared encodings for the multi-cycle control unit: FSM states, opcodes,
// ALU operation codes and the small opcode classifiers used by decode and sequencing.
package mc_pkg;

   typedef enum logic [2:0] {
      S_IF   = 3'b000,
      S_ID   = 3'b001,
      S_EXE  = 3'b010,
      S_MEM  = 3'b011,
      S_WB   = 3'b100,
      S_HALT = 3'b101
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'b000000;
   localparam logic [5:0] OP_SUB  = 6'b000001;
   localparam logic [5:0] OP_ADDI = 6'b000010;
   localparam logic [5:0] OP_OR   = 6'b010000;
   localparam logic [5:0] OP_AND  = 6'b010001;
   localparam logic [5:0] OP_ORI  = 6'b010010;
   localparam logic [5:0] OP_SLL  = 6'b011000;
   localparam logic [5:0] OP_SLT  = 6'b100110;
   localparam logic [5:0] OP_SW   = 6'b110000;
   localparam logic [5:0] OP_LW   = 6'b110001;
   localparam logic [5:0] OP_BEQ  = 6'b110100;
   localparam logic [5:0] OP_J    = 6'b111000;
   localparam logic [5:0] OP_JR   = 6'b111001;
   localparam logic [5:0] OP_JAL  = 6'b111010;
   localparam logic [5:0] OP_HALT = 6'b111111;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_SLL = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_AND = 3'b100;
   localparam logic [2:0] ALU_SLT = 3'b101;

   localparam logic [1:0] PC_NEXT   = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JR     = 2'b10;
   localparam logic [1:0] PC_JUMP   = 2'b11;

   localparam logic [1:0] DST_RA = 2'b00;
   localparam logic [1:0] DST_RT = 2'b01;
   localparam logic [1:0] DST_RD = 2'b10;

   function automatic logic is_rtype(input logic [5:0] op);
      return (op inside {OP_ADD, OP_SUB, OP_OR, OP_AND, OP_SLL, OP_SLT});
   endfunction

   function automatic logic is_alu_op(input logic [5:0] op);
      return is_rtype(op) || (op inside {OP_ADDI, OP_ORI});
   endfunction

   // Anything outside this set executes as a two-cycle NOP.
   function automatic logic is_decoded(input logic [5:0] op);
      return is_alu_op(op) ||
             (op inside {OP_SW, OP_LW, OP_BEQ, OP_J, OP_JR, OP_JAL, OP_HALT});
   endfunction

endpackage

// File: rtl/mc_control_unit_if.sv
// Control bus between the control unit (master) and the datapath (slave):
// opcode/zero flow in, strobes, mux selects and debug state flow out.
interface mc_control_unit_if;
   logic [5:0] opcode;
   logic       zero;
   logic       PCWre;
   logic       IRWre;
   logic       RegWre;
   logic       mRD;
   logic       mWR;
   logic       ALUSrcA;
   logic       ALUSrcB;
   logic       ExtSel;
   logic       DBDataSrc;
   logic       WrRegDSrc;
   logic [1:0] RegDst;
   logic [1:0] PCSrc;
   logic [2:0] ALUOp;
   logic [2:0] state;

   modport master (
      input  opcode, zero,
      output PCWre, IRWre, RegWre, mRD, mWR,
      output ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
      output RegDst, PCSrc, ALUOp, state
   );

   modport slave (
      output opcode, zero,
      input  PCWre, IRWre, RegWre, mRD, mWR,
      input  ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc,
      input  RegDst, PCSrc, ALUOp, state
   );
endinterface

// File: rtl/mc_ctrl_decode.sv
// Combinational control decode: current state, opcode and ALU zero flag to
// write strobes and datapath selects. Mux selects depend only on the opcode.
module mc_ctrl_decode
   import mc_pkg::*;
(
   input  state_t     i_state,
   input  logic [5:0] i_opcode,
   input  logic       i_zero,
   output logic       o_pc_wre,
   output logic       o_ir_wre,
   output logic       o_reg_wre,
   output logic       o_mem_rd,
   output logic       o_mem_wr,
   output logic       o_alu_src_a,
   output logic       o_alu_src_b,
   output logic       o_ext_sel,
   output logic       o_db_data_src,
   output logic       o_wr_reg_d_src,
   output logic [1:0] o_reg_dst,
   output logic [1:0] o_pc_src,
   output logic [2:0] o_alu_op
);

   always_comb begin
      o_pc_wre       = 1'b0;
      o_ir_wre       = 1'b0;
      o_reg_wre      = 1'b0;
      o_mem_rd       = 1'b0;
      o_mem_wr       = 1'b0;
      o_pc_src       = PC_NEXT;
      o_alu_src_a    = (i_opcode == OP_SLL);
      o_alu_src_b    = (i_opcode inside {OP_ADDI, OP_ORI, OP_LW, OP_SW});
      o_ext_sel      = (i_opcode != OP_ORI);
      o_db_data_src  = (i_opcode == OP_LW);
      o_wr_reg_d_src = (i_opcode != OP_JAL);
      o_reg_dst      = (i_opcode == OP_JAL) ? DST_RA :
                       is_rtype(i_opcode)   ? DST_RD : DST_RT;

      case (i_opcode)
         OP_SUB, OP_BEQ: o_alu_op = ALU_SUB;
         OP_SLL:         o_alu_op = ALU_SLL;
         OP_OR, OP_ORI:  o_alu_op = ALU_OR;
         OP_AND:         o_alu_op = ALU_AND;
         OP_SLT:         o_alu_op = ALU_SLT;
         default:        o_alu_op = ALU_ADD;
      endcase

      // Strobes fire only in the last state of each instruction, except IR and memory.
      case (i_state)
         S_IF: o_ir_wre = 1'b1;
         S_ID: begin
            case (i_opcode)
               OP_J: begin
                  o_pc_wre = 1'b1;
                  o_pc_src = PC_JUMP;
               end
               OP_JR: begin
                  o_pc_wre = 1'b1;
                  o_pc_src = PC_JR;
               end
               OP_JAL: begin
                  o_pc_wre  = 1'b1;
                  o_pc_src  = PC_JUMP;
                  o_reg_wre = 1'b1;
               end
               default: o_pc_wre = !is_decoded(i_opcode);
            endcase
         end
         S_EXE: begin
            if (i_opcode == OP_BEQ) begin
               o_pc_wre = 1'b1;
               o_pc_src = i_zero ? PC_BRANCH : PC_NEXT;
            end
         end
         S_MEM: begin
            o_mem_wr = (i_opcode == OP_SW);
            o_pc_wre = (i_opcode == OP_SW);
            o_mem_rd = (i_opcode == OP_LW);
         end
         S_WB: begin
            o_pc_wre  = 1'b1;
            o_reg_wre = 1'b1;
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/mc_control_unit.sv
// Multi-cycle processor control unit: Moore state register with next-state
// sequencing, plus write strobes gated off asynchronously while RST is high.
//
// state | meaning
// IF    | fetch, IR captures on exit
// ID    | decode; jumps, jal and NOPs retire here
// EXE   | ALU operation; beq retires here
// MEM   | data memory access; sw retires here
// WB    | register write-back for ALU ops and lw
// HALT  | stopped until RST
module mc_control_unit
   import mc_pkg::*;
(
   input logic           CLK,
   input logic           RST,
   mc_control_unit_if.master bus
);

   state_t r_state;

   logic       w_pc_wre;
   logic       w_ir_wre;
   logic       w_reg_wre;
   logic       w_mem_rd;
   logic       w_mem_wr;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state <= S_IF;
      end else begin
         case (r_state)
            S_IF: r_state <= S_ID;
            S_ID: begin
               if (bus.opcode inside {OP_J, OP_JR, OP_JAL})
                  r_state <= S_IF;
               else if (bus.opcode == OP_HALT)
                  r_state <= S_HALT;
               else if (!is_decoded(bus.opcode))
                  r_state <= S_IF;
               else
                  r_state <= S_EXE;
            end
            S_EXE: begin
               if (bus.opcode == OP_BEQ)
                  r_state <= S_IF;
               else if (bus.opcode inside {OP_LW, OP_SW})
                  r_state <= S_MEM;
               else
                  r_state <= S_WB;
            end
            S_MEM:   r_state <= (bus.opcode == OP_LW) ? S_WB : S_IF;
            S_WB:    r_state <= S_IF;
            S_HALT:  r_state <= S_HALT;
            default: r_state <= S_IF;
         endcase
      end
   end

   mc_ctrl_decode u_decode (
      .i_state        (r_state),
      .i_opcode       (bus.opcode),
      .i_zero         (bus.zero),
      .o_pc_wre       (w_pc_wre),
      .o_ir_wre       (w_ir_wre),
      .o_reg_wre      (w_reg_wre),
      .o_mem_rd       (w_mem_rd),
      .o_mem_wr       (w_mem_wr),
      .o_alu_src_a    (bus.ALUSrcA),
      .o_alu_src_b    (bus.ALUSrcB),
      .o_ext_sel      (bus.ExtSel),
      .o_db_data_src  (bus.DBDataSrc),
      .o_wr_reg_d_src (bus.WrRegDSrc),
      .o_reg_dst      (bus.RegDst),
      .o_pc_src       (bus.PCSrc),
      .o_alu_op       (bus.ALUOp)
   );

   // Gating by RST directly makes an abort drop strobes without waiting for a clock.
   assign bus.PCWre  = w_pc_wre  & ~RST;
   assign bus.IRWre  = w_ir_wre  & ~RST;
   assign bus.RegWre = w_reg_wre & ~RST;
   assign bus.mRD    = w_mem_rd  & ~RST;
   assign bus.mWR    = w_mem_wr  & ~RST;
   assign bus.state  = r_state;

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: instructions are modelled as a class, a cycle count
// and a step index; every falling edge the DUT outputs are checked against that model.
module tb_mc_control_unit;

   logic clk = 1'b0;
   logic rst;

   mc_control_unit_if bus_if();

   mc_control_unit dut (
      .CLK (clk),
      .RST (rst),
      .bus (bus_if)
   );

   always #5 clk = ~clk;

   typedef enum {C_ALU, C_LW, C_SW, C_BEQ, C_J, C_JR, C_JAL, C_HALT, C_NOP} cls_t;

   int         n_cmp = 0;
   int         n_err = 0;
   logic [5:0] m_op;
   int         m_step;
   logic       m_zero;
   bit         m_in_rst;
   bit         chk_en = 1'b0;
   cls_t       cm_c;
   bit         cm_last;
   logic [5:0] rnd_op;
   int         rnd_idx;
   logic [5:0] ops_tbl [14];

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t op=%b step=%0d)",
                  name, act, exp, $time, m_op, m_step);
      end
   endtask

   function automatic cls_t classify(input logic [5:0] op);
      case (op)
         6'b000000, 6'b000001, 6'b000010, 6'b010000,
         6'b010001, 6'b010010, 6'b011000, 6'b100110: return C_ALU;
         6'b110000: return C_SW;
         6'b110001: return C_LW;
         6'b110100: return C_BEQ;
         6'b111000: return C_J;
         6'b111001: return C_JR;
         6'b111010: return C_JAL;
         6'b111111: return C_HALT;
         default:   return C_NOP;
      endcase
   endfunction

   function automatic int n_cycles(input cls_t c);
      case (c)
         C_ALU:   return 4;
         C_LW:    return 5;
         C_SW:    return 4;
         C_BEQ:   return 3;
         default: return 2;
      endcase
   endfunction

   // IF,ID,EXE,MEM,WB numbered 0..4; ALU ops skip MEM; halt parks in 5.
   function automatic int exp_state(input cls_t c, input int step);
      if (c == C_HALT) return (step >= 2) ? 5 : step;
      if (c == C_ALU && step == 3) return 4;
      return step;
   endfunction

   function automatic int exp_aluop(input logic [5:0] op);
      case (op)
         6'b000001, 6'b110100: return 1;
         6'b011000:            return 2;
         6'b010000, 6'b010010: return 3;
         6'b010001:            return 4;
         6'b100110:            return 5;
         default:              return 0;
      endcase
   endfunction

   function automatic bit is_rtype(input logic [5:0] op);
      return op == 6'b000000 || op == 6'b000001 || op == 6'b010000 ||
             op == 6'b010001 || op == 6'b011000 || op == 6'b100110;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (m_in_rst) begin
            chk("rst_state",  8'(bus_if.state),  8'd0);
            chk("rst_PCWre",  8'(bus_if.PCWre),  8'd0);
            chk("rst_IRWre",  8'(bus_if.IRWre),  8'd0);
            chk("rst_RegWre", 8'(bus_if.RegWre), 8'd0);
            chk("rst_mRD",    8'(bus_if.mRD),    8'd0);
            chk("rst_mWR",    8'(bus_if.mWR),    8'd0);
         end else begin
            cm_c    = classify(m_op);
            cm_last = (cm_c != C_HALT) && (m_step == n_cycles(cm_c) - 1);
            chk("state",  8'(bus_if.state),  8'(exp_state(cm_c, m_step)));
            chk("IRWre",  8'(bus_if.IRWre),  8'(m_step == 0));
            chk("PCWre",  8'(bus_if.PCWre),  8'(cm_last));
            chk("RegWre", 8'(bus_if.RegWre),
                8'((((cm_c == C_ALU) || (cm_c == C_LW)) && cm_last) ||
                   ((cm_c == C_JAL) && m_step == 1)));
            chk("mRD", 8'(bus_if.mRD), 8'((cm_c == C_LW) && m_step == 3));
            chk("mWR", 8'(bus_if.mWR), 8'((cm_c == C_SW) && m_step == 3));
            if (cm_last) begin
               case (cm_c)
                  C_J, C_JAL: chk("PCSrc", 8'(bus_if.PCSrc), 8'd3);
                  C_JR:       chk("PCSrc", 8'(bus_if.PCSrc), 8'd2);
                  C_BEQ:      chk("PCSrc", 8'(bus_if.PCSrc), 8'(m_zero));
                  default:    chk("PCSrc", 8'(bus_if.PCSrc), 8'd0);
               endcase
            end
            if (m_step == 2 && cm_c inside {C_ALU, C_LW, C_SW, C_BEQ}) begin
               chk("ALUOp",   8'(bus_if.ALUOp),   8'(exp_aluop(m_op)));
               chk("ALUSrcA", 8'(bus_if.ALUSrcA), 8'(m_op == 6'b011000));
               chk("ALUSrcB", 8'(bus_if.ALUSrcB),
                   8'(m_op == 6'b000010 || m_op == 6'b010010 ||
                      m_op == 6'b110001 || m_op == 6'b110000));
               chk("ExtSel",  8'(bus_if.ExtSel),  8'(m_op != 6'b010010));
            end
            if (cm_last && (cm_c == C_ALU || cm_c == C_LW)) begin
               chk("DBDataSrc", 8'(bus_if.DBDataSrc), 8'(cm_c == C_LW));
               chk("WrRegDSrc", 8'(bus_if.WrRegDSrc), 8'd1);
               chk("RegDst",    8'(bus_if.RegDst),    is_rtype(m_op) ? 8'd2 : 8'd1);
            end
            if (cm_c == C_JAL && m_step == 1) begin
               chk("jal_RegDst",    8'(bus_if.RegDst),    8'd0);
               chk("jal_WrRegDSrc", 8'(bus_if.WrRegDSrc), 8'd0);
            end
         end
      end
   end

   // Advance one clock; step 1 is ID, where the newly fetched opcode appears.
   task automatic step(input int k, input logic [5:0] op, input int zv);
      @(posedge clk);
      #1;
      m_step = k;
      if (k == 1) begin
         m_op          = op;
         bus_if.opcode = op;
      end
      m_zero      = (zv < 0) ? 1'($urandom_range(0, 1)) : 1'(zv);
      bus_if.zero = m_zero;
   endtask

   task automatic run_instr(input logic [5:0] op, input int zv);
      for (int k = 1; k < n_cycles(classify(op)); k++) step(k, op, zv);
      step(0, op, zv);
   endtask

   task automatic release_rst();
      @(posedge clk);
      #1;
      rst      = 1'b0;
      m_in_rst = 1'b0;
      m_step   = 0;
   endtask

   task automatic run_random(input int n);
      for (int i = 0; i < n; i++) begin
         rnd_idx = int'($urandom_range(0, 15));
         if (rnd_idx < 14) begin
            rnd_op = ops_tbl[rnd_idx];
         end else begin
            rnd_op = 6'($urandom_range(0, 63));
            if (rnd_op == 6'b111111) rnd_op = 6'b000011;
         end
         run_instr(rnd_op, -1);
      end
   endtask

   initial begin
      ops_tbl = '{6'b000000, 6'b000001, 6'b000010, 6'b010000, 6'b010001,
                  6'b010010, 6'b011000, 6'b100110, 6'b110000, 6'b110001,
                  6'b110100, 6'b111000, 6'b111001, 6'b111010};
      rst           = 1'b1;
      m_in_rst      = 1'b1;
      m_step        = 0;
      m_op          = 6'b000000;
      m_zero        = 1'b0;
      bus_if.opcode = 6'b000000;
      bus_if.zero   = 1'b0;
      #1 chk_en     = 1'b1;

      repeat (3) @(posedge clk);
      #1;
      chk("lit_rst_IRWre", 8'(bus_if.IRWre), 8'd0);
      chk("lit_rst_state", 8'(bus_if.state), 8'd0);
      rst      = 1'b0;
      m_in_rst = 1'b0;
      m_step   = 0;
      #1;
      chk("lit_post_rst_IRWre", 8'(bus_if.IRWre), 8'd1);
      chk("lit_post_rst_state", 8'(bus_if.state), 8'd0);

      // lw walks all five states
      step(1, 6'b110001, -1);
      step(2, 6'b110001, -1);
      step(3, 6'b110001, -1);
      #1;
      chk("lit_lw_mem_state", 8'(bus_if.state), 8'd3);
      chk("lit_lw_mem_mRD",   8'(bus_if.mRD),   8'd1);
      step(4, 6'b110001, -1);
      #1;
      chk("lit_lw_wb_state",     8'(bus_if.state),     8'd4);
      chk("lit_lw_wb_RegWre",    8'(bus_if.RegWre),    8'd1);
      chk("lit_lw_wb_DBDataSrc", 8'(bus_if.DBDataSrc), 8'd1);
      chk("lit_lw_wb_PCWre",     8'(bus_if.PCWre),     8'd1);
      step(0, 6'b110001, -1);

      // beq taken, then not taken
      step(1, 6'b110100, 1);
      step(2, 6'b110100, 1);
      #1 chk("lit_beq_taken_PCSrc", 8'(bus_if.PCSrc), 8'd1);
      step(0, 6'b110100, 1);
      step(1, 6'b110100, 0);
      step(2, 6'b110100, 0);
      #1 chk("lit_beq_not_taken_PCSrc", 8'(bus_if.PCSrc), 8'd0);
      step(0, 6'b110100, 0);

      // jal retires in ID
      step(1, 6'b111010, -1);
      #1;
      chk("lit_jal_RegWre", 8'(bus_if.RegWre), 8'd1);
      chk("lit_jal_RegDst", 8'(bus_if.RegDst), 8'd0);
      chk("lit_jal_PCSrc",  8'(bus_if.PCSrc),  8'd3);
      chk("lit_jal_PCWre",  8'(bus_if.PCWre),  8'd1);
      step(0, 6'b111010, -1);

      run_random(150);

      // reset in MEM of sw aborts the memory write at once
      step(1, 6'b110000, -1);
      step(2, 6'b110000, -1);
      step(3, 6'b110000, -1);
      #1 chk("lit_sw_mem_mWR", 8'(bus_if.mWR), 8'd1);
      rst      = 1'b1;
      m_in_rst = 1'b1;
      #1;
      chk("lit_sw_abort_mWR",   8'(bus_if.mWR),   8'd0);
      chk("lit_sw_abort_state", 8'(bus_if.state), 8'd0);
      repeat (2) @(posedge clk);
      release_rst();

      // halt parks until reset
      step(1, 6'b111111, -1);
      repeat (20) step(2, 6'b111111, -1);
      #1;
      chk("lit_halt_state", 8'(bus_if.state), 8'd5);
      chk("lit_halt_PCWre", 8'(bus_if.PCWre), 8'd0);
      chk("lit_halt_IRWre", 8'(bus_if.IRWre), 8'd0);
      rst      = 1'b1;
      m_in_rst = 1'b1;
      #1 chk("lit_halt_rst_state", 8'(bus_if.state), 8'd0);
      repeat (2) @(posedge clk);
      release_rst();

      run_random(20);

      @(posedge clk);
      chk_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/mc_control_unit.md
MC_CONTROL_UNIT -- requirements
Module: mc_control_unit

Interface
REQ-001 SHALL have port CLK, input, 1, rising-edge system clock shared with IR, PC, register file and data memory.
REQ-002 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port opcode, input, 6, instruction bits [31:26] from the IR output.
REQ-004 SHALL have port zero, input, 1, ALU zero flag.
REQ-005 SHALL have ports PCWre, IRWre, RegWre, mRD, mWR, input-less outputs, 1 each: PC write, IR write, register-file write, data-memory read, data-memory write.
REQ-006 SHALL have outputs ALUSrcA, ALUSrcB, ExtSel, DBDataSrc, WrRegDSrc, 1 each: shamt/rs select, imm/rt select, sign(1)/zero(0) extend, memory(1)/ALU(0) writeback, ALU-or-mem(1)/PC+4(0) writeback.
REQ-007 SHALL have outputs RegDst 2 (00 $31, 01 rt, 10 rd), PCSrc 2 (00 PC+4, 01 branch, 10 jr, 11 jump), ALUOp 3.
REQ-008 SHALL have output state, 3, current FSM state for debug.

Function
REQ-009 SHALL implement a Moore FSM with states IF=000, ID=001, EXE=010, MEM=011, WB=100, HALT=101.
REQ-010 SHALL decode opcodes: add 000000, sub 000001, addi 000010, or 010000, and 010001, ori 010010, sll 011000, slt 100110, sw 110000, lw 110001, beq 110100, j 111000, jr 111001, jal 111010, halt 111111.
REQ-011 SHALL transition IF->ID unconditionally.
REQ-012 SHALL transition ID->IF for j, jr, jal; ID->HALT for halt; ID->IF for any undecoded opcode (NOP); ID->EXE otherwise.
REQ-013 SHALL transition EXE->IF for beq; EXE->MEM for lw/sw; EXE->WB for ALU instructions.
REQ-014 SHALL transition MEM->WB for lw, MEM->IF for sw; WB->IF always; HALT->HALT until RST.
REQ-015 SHALL give cycle counts: j/jr/jal 2, beq 3, ALU 4, sw 4, lw 5.
REQ-016 SHALL assert IRWre only in IF, so IR captures on the IF->ID edge.
REQ-017 SHALL assert PCWre only in the final state of each instruction (ID for jumps, EXE for beq, MEM for sw, WB for ALU/lw); never in HALT or for undecoded opcodes' ID... except NOP which SHALL assert PCWre in ID with PCSrc=00.
REQ-018 SHALL set PCSrc=01 in EXE for beq only when zero=1, else 00.
REQ-019 SHALL assert RegWre in WB for ALU/lw and in ID for jal (RegDst=00, WrRegDSrc=0); never otherwise.
REQ-020 SHALL assert mWR only in MEM for sw, mRD only in MEM for lw.
REQ-021 SHALL drive ALUOp: add/addi/lw/sw 000, sub/beq 001, sll 010, or/ori 011, and 100, slt 101; ALUSrcA=1 only for sll; ALUSrcB=1 for addi/ori/lw/sw; ExtSel=0 only for ori.
REQ-022 SHALL hold all data-path outputs stable for the full duration of each state (no glitches relative to CLK edges; opcode stable from ID onward).

Reset
REQ-023 SHALL force state to IF asynchronously on RST rising.
REQ-024 SHALL drive PCWre, IRWre, RegWre, mRD, mWR to 0 while RST is high, overriding the IF decode.
REQ-025 SHALL resume with IRWre=1 in the first cycle after RST deasserts; RST mid-instruction SHALL abort with no write strobe asserted.

Structure
REQ-026 SHALL place state encodings, opcode constants and ALUOp codes in shared package mc_pkg.
REQ-027 SHALL split into state register/next-state logic plus one combinational sub-module mc_ctrl_decode (state, opcode, zero -> control outputs).

Verification
REQ-028 Reset: RST=1 for 3 cycles then 0 -> outputs strobes 0 during reset; state=000, IRWre=1 on first post-reset cycle.
REQ-029 lw (110001): state sequence 000,001,010,011,100; mRD=1 only in 011; RegWre=1, DBDataSrc=1, PCWre=1 only in 100.
REQ-030 beq (110100) with zero=1 then zero=0: 3 cycles each; PCSrc=01 then 00 in EXE; RegWre, mWR never 1.
REQ-031 jal (111010): 2 cycles; in ID RegWre=1, RegDst=00, WrRegDSrc=0, PCSrc=11, PCWre=1.
REQ-032 halt (111111): state reaches 101 and stays 20 cycles with PCWre=IRWre=0; RST recovers to 000.
REQ-033 RST asserted in MEM of sw: mWR drops to 0 immediately, state=000 asynchronously.
